// File: rtl/trigger_pulse_pkg.sv
// trigger_pulse_pkg: shared types and constants for the trigger pulse shaper.
//   pulse_state_t   - shaper FSM states
//   *_DEF           - default parameter values
//   DROP_SAT        - all-ones saturation value; sliced to DROP_BITS by users
package trigger_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HIGH    = 2'd1,
        LOW     = 2'd2,
        HOLDOFF = 2'd3
    } pulse_state_t;

    localparam int TIME_BITS_DEF  = 32;
    localparam int COUNT_BITS_DEF = 8;
    localparam int DROP_BITS_DEF  = 16;

    // Wide enough for any DROP_BITS up to 64; users take the low DROP_BITS.
    localparam logic [63:0] DROP_SAT = '1;

endpackage

// File: rtl/trigger_pulse_shaper_timer.sv
// pulse_timer: loadable down-counter shared by the HIGH, LOW and HOLDOFF phases.
//   clk, rst    - clock, async active-high reset
//   load        - load value with load_value this cycle
//   load_value  - cycles-1 of the phase being entered
//   value       - current count
//   expire      - value has reached zero (last cycle of the phase)
module pulse_timer
    import trigger_pulse_pkg::*;
#(
    parameter int TIME_BITS = TIME_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [TIME_BITS-1:0] load_value,
    output logic [TIME_BITS-1:0] value,
    output logic                 expire
);

    localparam logic [TIME_BITS-1:0] T_ONE = TIME_BITS'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - T_ONE;
        end
    end

    assign expire = (value == '0);

endmodule

// File: rtl/trigger_pulse_shaper.sv
// trigger_pulse_shaper: turns a single-cycle delayed trigger into a burst of
// cfg_count pulses (width/gap in cycles) followed by a re-arm holdoff.
//   clk, rst        - clock, async active-high reset
//   trig_in         - single-cycle trigger
//   arm_en          - gate for accepting new triggers
//   cfg_width/gap   - pulse high/low time in cycles (0 behaves as 1)
//   cfg_count       - pulses per burst (0 ignores triggers)
//   cfg_holdoff     - idle cycles after the last pulse before re-arm
//   clr_dropped     - clear the dropped-trigger counter
//   pulse_out       - registered shaped output
//   busy            - FSM not idle
//   burst_done      - one cycle on return to IDLE after a burst
//   dropped_count   - saturating count of triggers seen while busy
module trigger_pulse_shaper
    import trigger_pulse_pkg::*;
#(
    parameter int TIME_BITS  = TIME_BITS_DEF,
    parameter int COUNT_BITS = COUNT_BITS_DEF,
    parameter int DROP_BITS  = DROP_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trig_in,
    input  logic                  arm_en,
    input  logic [TIME_BITS-1:0]  cfg_width,
    input  logic [TIME_BITS-1:0]  cfg_gap,
    input  logic [COUNT_BITS-1:0] cfg_count,
    input  logic [TIME_BITS-1:0]  cfg_holdoff,
    input  logic                  clr_dropped,
    output logic                  pulse_out,
    output logic                  busy,
    output logic                  burst_done,
    output logic [DROP_BITS-1:0]  dropped_count
);

    localparam logic [TIME_BITS-1:0]  T_ONE    = TIME_BITS'(1);
    localparam logic [COUNT_BITS-1:0] C_ONE    = COUNT_BITS'(1);
    localparam logic [DROP_BITS-1:0]  D_ONE    = DROP_BITS'(1);
    localparam logic [DROP_BITS-1:0]  DROP_MAX = DROP_SAT[DROP_BITS-1:0];

    pulse_state_t state, next_state;

    // Snapshots of the running burst; width/gap held as cycles-1 so a
    // zero config naturally maps to a one-cycle phase.
    logic [TIME_BITS-1:0]  width_m1;
    logic [TIME_BITS-1:0]  gap_m1;
    logic [TIME_BITS-1:0]  holdoff;
    logic [COUNT_BITS-1:0] remaining;

    logic                  accept;
    logic [TIME_BITS-1:0]  cfg_width_m1;
    logic [TIME_BITS-1:0]  cfg_gap_m1;
    logic                  tmr_load;
    logic [TIME_BITS-1:0]  tmr_value;
    logic [TIME_BITS-1:0]  tmr_count;
    logic                  tmr_expire;

    assign accept       = (state == IDLE) && trig_in && arm_en && (cfg_count != '0);
    assign cfg_width_m1 = (cfg_width == '0) ? '0 : cfg_width - T_ONE;
    assign cfg_gap_m1   = (cfg_gap == '0) ? '0 : cfg_gap - T_ONE;

    pulse_timer #(.TIME_BITS(TIME_BITS)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_value),
        .value      (tmr_count),
        .expire     (tmr_expire)
    );

    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_value  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = HIGH;
                    tmr_load   = 1'b1;
                    tmr_value  = cfg_width_m1;
                end
            end
            HIGH: begin
                if (tmr_expire) begin
                    if (remaining > C_ONE) begin
                        next_state = LOW;
                        tmr_load   = 1'b1;
                        tmr_value  = gap_m1;
                    end else if (holdoff != '0) begin
                        next_state = HOLDOFF;
                        tmr_load   = 1'b1;
                        tmr_value  = holdoff - T_ONE;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            LOW: begin
                if (tmr_expire) begin
                    next_state = HIGH;
                    tmr_load   = 1'b1;
                    tmr_value  = width_m1;
                end
            end
            HOLDOFF: begin
                if (tmr_expire) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pulse_out  <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            state      <= next_state;
            // Registered copy of "state is HIGH" so the pin sees a flop.
            pulse_out  <= (next_state == HIGH);
            burst_done <= (state != IDLE) && (next_state == IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_m1  <= '0;
            gap_m1    <= '0;
            holdoff   <= '0;
            remaining <= '0;
        end else if (accept) begin
            width_m1  <= cfg_width_m1;
            gap_m1    <= cfg_gap_m1;
            holdoff   <= cfg_holdoff;
            remaining <= cfg_count;
        end else if (state == LOW && tmr_expire) begin
            remaining <= remaining - C_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropped_count <= '0;
        end else if (clr_dropped) begin
            dropped_count <= '0;
        end else if (trig_in && state != IDLE && dropped_count != DROP_MAX) begin
            dropped_count <= dropped_count + D_ONE;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_trigger_pulse_shaper.sv
module tb_trigger_pulse_shaper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trig_in = 1'b0;
    logic        arm_en = 1'b0;
    logic [31:0] cfg_width = '0;
    logic [31:0] cfg_gap = '0;
    logic [7:0]  cfg_count = '0;
    logic [31:0] cfg_holdoff = '0;
    logic        clr_dropped = 1'b0;
    logic        pulse_out;
    logic        busy;
    logic        burst_done;
    logic [15:0] dropped_count;

    trigger_pulse_shaper dut (
        .clk           (clk),
        .rst           (rst),
        .trig_in       (trig_in),
        .arm_en        (arm_en),
        .cfg_width     (cfg_width),
        .cfg_gap       (cfg_gap),
        .cfg_count     (cfg_count),
        .cfg_holdoff   (cfg_holdoff),
        .clr_dropped   (clr_dropped),
        .pulse_out     (pulse_out),
        .busy          (busy),
        .burst_done    (burst_done),
        .dropped_count (dropped_count)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: each accepted burst is described by its accept cycle
    // and parameters; every expected output is derived from that arithmetic.
    typedef struct {
        longint t; longint w; longint g; longint n; longint h; longint e;
    } burst_t;
    typedef struct {
        longint c; longint v;
    } drop_t;

    burst_t burst_q[$];
    drop_t  drop_q[$];
    longint idle_at  = 0;
    longint exp_drop = 0;
    int     checks = 0;
    int     errors = 0;

    // Config staged by the stimulus; applied to the DUT inside drive().
    logic [31:0] cw = '0, cg = '0, ch = '0;
    logic [7:0]  cn = '0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit trig, input bit arm, input bit clr);
        longint t;
        bit     busy_m;
        burst_t b;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        trig_in     = trig;
        arm_en      = arm;
        clr_dropped = clr;
        cfg_width   = cw;
        cfg_gap     = cg;
        cfg_count   = cn;
        cfg_holdoff = ch;
        t      = cyc;
        busy_m = (t < idle_at);
        if (clr) exp_drop = 0;
        else if (trig && busy_m && exp_drop < 65535) exp_drop++;
        drop_q.push_back('{t + 1, exp_drop});
        if (trig && arm && cn != 0 && !busy_m) begin
            b.t = t;
            b.w = (cw == 0) ? 1 : longint'(cw);
            b.g = (cg == 0) ? 1 : longint'(cg);
            b.n = longint'(cn);
            b.h = longint'(ch);
            b.e = t + 1 + b.n * b.w + (b.n - 1) * b.g + b.h;
            burst_q.push_back(b);
            idle_at = b.e;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        trig_in     = 1'b0;
        clr_dropped = 1'b0;
        burst_q.delete();
        drop_q.delete();
        idle_at  = 0;
        exp_drop = 0;
        for (int i = 1; i < n; i++) @(posedge clk);
    endtask

    // Monitor: derives expectations for this cycle from the burst queue and
    // pops a burst whenever the DUT reports burst_done.
    always @(negedge clk) begin
        longint c, rel, span;
        bit     ep, eb;
        c = cyc;
        if (rst) begin
            check("rst_pulse", longint'(pulse_out), 0);
            check("rst_busy", longint'(busy), 0);
            check("rst_done", longint'(burst_done), 0);
            check("rst_dropped", longint'(dropped_count), 0);
        end else begin
            ep = 1'b0;
            eb = 1'b0;
            foreach (burst_q[i]) begin
                if (c > burst_q[i].t && c < burst_q[i].e) eb = 1'b1;
                rel  = c - burst_q[i].t - 1;
                span = burst_q[i].n * burst_q[i].w + (burst_q[i].n - 1) * burst_q[i].g;
                if (rel >= 0 && rel < span && (rel % (burst_q[i].w + burst_q[i].g)) < burst_q[i].w)
                    ep = 1'b1;
            end
            check("pulse_out", longint'(pulse_out), longint'(ep));
            check("busy", longint'(busy), longint'(eb));
            if (burst_done) begin
                if (burst_q.size() == 0) begin
                    check("burst_done_unexpected", 1, 0);
                end else begin
                    check("burst_done_cycle", c, burst_q[0].e);
                    void'(burst_q.pop_front());
                end
            end else if (burst_q.size() != 0 && burst_q[0].e <= c) begin
                check("burst_done_missing", 0, 1);
                void'(burst_q.pop_front());
            end
            while (drop_q.size() != 0 && drop_q[0].c < c) void'(drop_q.pop_front());
            if (drop_q.size() != 0 && drop_q[0].c == c) begin
                check("dropped_count", longint'(dropped_count), drop_q[0].v);
                void'(drop_q.pop_front());
            end
        end
    end

    initial begin
        int k;
        do_reset(3);

        // single pulse, no holdoff
        cw = 3; cg = 2; cn = 1; ch = 0;
        drive(1, 1, 0);
        idle(6);

        // three pulses with holdoff; trigger on last holdoff cycle dropped,
        // trigger on the first IDLE cycle accepted
        cw = 2; cg = 4; cn = 3; ch = 5;
        drive(1, 1, 0);
        idle(18);
        drive(1, 1, 0);
        drive(1, 1, 0);
        idle(25);

        // zero width/gap behave as one
        cw = 0; cg = 0; cn = 2; ch = 0;
        drive(1, 1, 0);
        idle(6);

        // config change mid-burst only affects the next burst
        cw = 2; cg = 1; cn = 2; ch = 1;
        drive(1, 1, 0);
        cw = 10;
        idle(10);
        drive(1, 1, 0);
        idle(30);

        // reset mid-HIGH after a drop, then gated triggers are ignored
        cw = 5; cg = 1; cn = 1; ch = 0;
        drive(1, 1, 0);
        drive(1, 1, 0);
        do_reset(2);
        drive(1, 0, 0);
        cn = 0;
        drive(1, 1, 0);
        idle(4);

        // dropped counter saturation, then clear beats a coincident drop
        cw = 65545; cg = 1; cn = 1; ch = 0;
        drive(1, 1, 0);
        for (int i = 0; i < 65537; i++) drive(1, 1, 0);
        drive(1, 1, 1);
        idle(10);

        // randomized traffic with small timing values
        cw = 2; cg = 1; cn = 2; ch = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) begin
                cw = $urandom_range(4);
                cg = $urandom_range(4);
                cn = 8'($urandom_range(3));
                ch = $urandom_range(4);
            end
            drive($urandom_range(2) == 0, $urandom_range(7) != 0, $urandom_range(31) == 0);
        end

        // drain, bounded
        k = 0;
        while (burst_q.size() != 0 && k < 200) begin
            idle(1);
            k++;
        end
        idle(2);
        if (burst_q.size() != 0) check("drain_timeout", longint'(burst_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trigger_pulse_shaper.md
Name: trigger_pulse_shaper

Overview:
- Sits directly downstream of the trigger delay stage.
- Consumes its delayed, single-cycle trigger pulse and produces the physical trigger output: a burst of N pulses with programmable high width and gap, followed by a re-arm holdoff.
- Configuration comes from the UART command state machine as level registers.
- Busy and dropped-trigger status are fed back for status readout.

Parameters:
- TIME_BITS, 32, width of the width/gap/holdoff cycle counters
- COUNT_BITS, 8, width of the pulses-per-burst field
- DROP_BITS, 16, width of the dropped-trigger counter

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  reset, asynchronous, active-high
- trig_in  in  1  single-cycle delayed trigger pulse, synchronous to clk
- arm_en  in  1  1 = accept new triggers
- cfg_width  in  TIME_BITS  pulse high time in cycles; 0 treated as 1
- cfg_gap  in  TIME_BITS  low time between pulses in cycles; 0 treated as 1
- cfg_count  in  COUNT_BITS  pulses per burst; 0 = triggers ignored
- cfg_holdoff  in  TIME_BITS  cycles after last pulse before re-arm; 0 allowed
- clr_dropped  in  1  single-cycle clear of dropped counter
- pulse_out  out  1  shaped trigger output, registered
- busy  out  1  high whenever state is not IDLE
- burst_done  out  1  single-cycle pulse on return to IDLE after a burst
- dropped_count  out  DROP_BITS  triggers received while busy, saturating

Behaviour:
- Reset (async, immediate, also mid-burst):
  - state=IDLE; pulse_out=0, busy=0, burst_done=0, dropped_count=0.
  - Snapshot registers cleared.
- States: IDLE, HIGH, LOW, HOLDOFF.
- Accept condition: state register==IDLE && trig_in && arm_en && cfg_count!=0.
  - Snapshot width/gap/count/holdoff at acceptance; later cfg changes do not affect the running burst.
- Timing (trigger accepted in cycle T, W=max(cfg_width,1), G=max(cfg_gap,1), H=cfg_holdoff):
  - pulse_out high in cycles T+1..T+W (latency 1 cycle).
  - If pulses remain: LOW for G cycles, then next HIGH for W cycles.
  - After last HIGH: HOLDOFF for H cycles, then IDLE. If H=0, go directly to IDLE on the cycle after the last high.
  - Burst duration in cycles: N*W + (N-1)*G + H.
- Transitions:
  - IDLE->HIGH on accept.
  - HIGH->LOW when the timer expires and remaining>1.
  - HIGH->HOLDOFF when the timer expires, remaining==1, and H>0.
  - HIGH->IDLE when the timer expires, remaining==1, and H=0.
  - LOW->HIGH when the timer expires; decrement remaining.
  - HOLDOFF->IDLE when the timer expires.
- busy: pulse_out drives from state==HIGH (registered); busy=(state!=IDLE).
- burst_done: 1 in the first IDLE cycle after a burst; never after reset.
- Trigger in same cycle as entry into IDLE: accepted, since the state register already reads IDLE. A trigger arriving on the last HOLDOFF cycle is dropped.
- Dropped triggers:
  - trig_in while state!=IDLE increments dropped_count, saturating at all-ones.
  - Triggers blocked by arm_en=0 or cfg_count=0 in IDLE are ignored and not counted.
  - clr_dropped and a drop in the same cycle: clear wins, result 0.
- arm_en deasserted mid-burst: the burst completes, including holdoff; only new acceptance is gated.
- Timers are TIME_BITS down-counters. All arithmetic is unsigned with no wrap: a count of 2^TIME_BITS-1 is legal.

Decomposition:
- Package trigger_pulse_pkg holds:
  - the state enum pulse_state_t (IDLE, HIGH, LOW, HOLDOFF)
  - default parameter constants
  - the DROP_SAT constant
- One sub-module is natural: pulse_timer.
  - Loadable TIME_BITS down-counter with load, value, and expire outputs.
  - Shared by the HIGH, LOW and HOLDOFF states.
- No other hierarchy.

Test Plan:
- W=3, G=2, N=1, H=0; trig at T → pulse_out high T+1..T+3; busy T+1..T+3; burst_done at T+4.
- W=2, G=4, N=3, H=5; trig at T → highs at T+1..2, T+7..8, T+13..14; IDLE at T+20; second trig at T+19 dropped (dropped_count=1); trig at T+20 accepted.
- W=0, G=0, N=2 → treated as W=1, G=1: highs at T+1 and T+3.
- Change cfg_width from 2 to 10 at T+1 during burst → current burst keeps width 2; next accepted burst uses 10.
- Assert rst at T+2 mid-HIGH → pulse_out=0 immediately; state IDLE; dropped_count=0. arm_en=0 or cfg_count=0 with trig → no pulse, dropped_count unchanged.
- Preload dropped_count to 0xFFFE, drop 3 triggers → 0xFFFF and holds. Then clr_dropped coincident with a drop → 0.
